alu_op_sequencer: RTL and testbench

- Front-end controller for the 8-bit ALU function units (AND, OR, XOR, ADD, SUB, MUL, ...). Each unit uses the one-cycle start / one-cycle done handshake and returns a 16-bit result.
- Accepts one operation request at a time over a valid/ready interface and registers the operands.
- Pulses `start` on the selected unit, waits for its `done` under a watchdog, then captures the result.
- Presents the result on a valid/ready response port.
- Sits between the top-level command decoder and the bank of unit instances, which share one operand bus.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_result_mux.sv | 43 ++++
 rtl/alu_op_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU front-end sequencer and its helpers.
//
// Contents:
//   DATA_W / RES_W   operand width and unit result width
//   OP_*             opcode (= unit slot index) assignments
//   ST_*             sequencer state encodings
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 16;

    // Opcode is the slot index of the unit in the function-unit bank.
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    // Sequencer states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/alu_result_mux.sv
// Combinational selector for the function-unit bank: picks the 16-bit
// result slot and the done bit of the unit addressed by op. An op that
// points past the last slot selects zero / not-done.
//
// Ports:
//   op         in   OP_W             unit select
//   unit_res   in   RES_W*N_UNITS    flattened results, slot i at [16i+15:16i]
//   unit_done  in   N_UNITS          per-unit done
//   res        out  RES_W            selected result
//   done       out  1                selected done
module alu_result_mux
    import alu_pkg::*;
#(
    parameter int N_UNITS = 8,
    parameter int OP_W    = 3
) (
    input  logic [OP_W-1:0]          op,
    input  logic [RES_W*N_UNITS-1:0] unit_res,
    input  logic [N_UNITS-1:0]       unit_done,
    output logic [RES_W-1:0]         res,
    output logic                     done
);

    logic [RES_W-1:0] slot [N_UNITS];

    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_slot
        assign slot[gi] = unit_res[gi*RES_W +: RES_W];
    end

    // Compare against each slot index instead of indexing with op directly,
    // so an out-of-range op cleanly yields zero for any N_UNITS.
    always_comb begin
        res  = '0;
        done = 1'b0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (int'(op) == i) begin
                res  = slot[i];
                done = unit_done[i];
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the bank of 8-bit ALU function units. Accepts one
// request at a time, pulses start on the selected unit for exactly one cycle,
// waits for its done under a watchdog, and presents the captured result (or
// an error for illegal opcode / timeout) on a valid/ready response port.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake; req_op/req_a/req_b payload
//   rsp_valid/rsp_ready    response handshake; rsp_res/rsp_op/rsp_err payload
//   unit_start             one-hot start pulse to the unit bank
//   unit_a/unit_b          shared operand bus, held from ISSUE until next accept
//   unit_res/unit_done     flattened unit results and per-unit done
//   busy                   high whenever not IDLE
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int                 N_UNITS   = 8,
    parameter int                 OP_W      = 3,
    parameter logic [N_UNITS-1:0] UNIT_MASK = {N_UNITS{1'b1}},
    parameter int                 TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [OP_W-1:0]          req_op,
    input  logic [DATA_W-1:0]        req_a,
    input  logic [DATA_W-1:0]        req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RES_W-1:0]         rsp_res,
    output logic [OP_W-1:0]          rsp_op,
    output logic                     rsp_err,
    output logic [N_UNITS-1:0]       unit_start,
    output logic [DATA_W-1:0]        unit_a,
    output logic [DATA_W-1:0]        unit_b,
    input  logic [RES_W*N_UNITS-1:0] unit_res,
    input  logic [N_UNITS-1:0]       unit_done,
    output logic                     busy
);

    // Watchdog only counts 0..TIMEOUT-1 and is cleared on the way into WAIT.
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [1:0]        state_reg, state_next;
    logic [OP_W-1:0]   op_reg,    op_next;
    logic [DATA_W-1:0] a_reg,     a_next;
    logic [DATA_W-1:0] b_reg,     b_next;
    logic [RES_W-1:0]  res_reg,   res_next;
    logic              err_reg,   err_next;
    logic [WD_W-1:0]   wd_reg,    wd_next;

    logic              accept;
    logic              req_legal;
    logic [RES_W-1:0]  sel_res;
    logic              sel_done;

    // Only the latched opcode's slot is looked at, so done pulses from any
    // other unit are ignored in every state.
    alu_result_mux #(
        .N_UNITS (N_UNITS),
        .OP_W    (OP_W)
    ) u_result_mux (
        .op        (op_reg),
        .unit_res  (unit_res),
        .unit_done (unit_done),
        .res       (sel_res),
        .done      (sel_done)
    );

    assign accept = req_valid && req_ready;

    // An opcode is legal only if it names an existing, populated slot.
    always_comb begin
        req_legal = 1'b0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (int'(req_op) == i && UNIT_MASK[i]) begin
                req_legal = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        err_next   = err_reg;
        wd_next    = wd_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    op_next = req_op;
                    a_next  = req_a;
                    b_next  = req_b;
                    if (req_legal) begin
                        state_next = ST_ISSUE;
                    end else begin
                        // Illegal op never touches the unit bank.
                        res_next   = '0;
                        err_next   = 1'b1;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                wd_next    = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // done is checked first so it wins over a same-cycle timeout.
                if (sel_done) begin
                    res_next   = sel_res;
                    err_next   = 1'b0;
                    state_next = ST_RESP;
                end else if (wd_reg == WD_LAST) begin
                    res_next   = '0;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            err_reg   <= 1'b0;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            err_reg   <= err_next;
            wd_reg    <= wd_next;
        end
    end

    // Start is decoded from the ISSUE state, which lasts exactly one cycle,
    // so it can never be high two cycles in a row.
    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_start
        assign unit_start[gi] = (state_reg == ST_ISSUE) && (op_reg == OP_W'(gi));
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign busy      = (state_reg != ST_IDLE);
    assign rsp_res   = res_reg;
    assign rsp_op    = op_reg;
    assign rsp_err   = err_reg;
    assign unit_a    = a_reg;
    assign unit_b    = b_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer (UNIT_MASK=8'h7F, TIMEOUT=8).
// A behavioural unit bank answers each start after a programmable number of
// edges; expected results are hand-computed constants.
module tb_alu_op_sequencer;

    localparam int N_UNITS = 8;
    localparam int OP_W    = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic [OP_W-1:0]     req_op;
    logic [7:0]          req_a;
    logic [7:0]          req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [15:0]         rsp_res;
    logic [OP_W-1:0]     rsp_op;
    logic                rsp_err;
    logic [N_UNITS-1:0]  unit_start;
    logic [7:0]          unit_a;
    logic [7:0]          unit_b;
    logic [16*N_UNITS-1:0] unit_res;
    logic [N_UNITS-1:0]  unit_done;
    logic                busy;

    // Unit bank model
    logic [16*N_UNITS-1:0] model_res  = '0;
    logic [N_UNITS-1:0]    model_done = '0;
    logic [N_UNITS-1:0]    extra_done;
    logic                  model_en;
    int                    model_lat;
    logic                  pend = 1'b0;
    int                    pend_op = 0;
    int                    pend_cnt = 0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign unit_res  = model_res;
    assign unit_done = model_done | extra_done;

    alu_op_sequencer #(
        .N_UNITS   (N_UNITS),
        .OP_W      (OP_W),
        .UNIT_MASK (8'h7F),
        .TIMEOUT   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .unit_start (unit_start),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_res   (unit_res),
        .unit_done  (unit_done),
        .busy       (busy)
    );

    function automatic logic [15:0] unit_calc(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0:       return {8'h00, a & b};
            1:       return {8'h00, a | b};
            2:       return {8'h00, a ^ b};
            3:       return 16'(a) + 16'(b);
            default: return 16'(a) * 16'(b);
        endcase
    endfunction

    // A unit seeing start at edge E raises done for one cycle after edge
    // E+model_lat, sampling operands when it does so.
    always @(posedge clk) begin
        model_done <= '0;
        if (pend) begin
            if (pend_cnt <= 1) begin
                model_done[pend_op] <= 1'b1;
                model_res[pend_op*16 +: 16] <= unit_calc(pend_op, unit_a, unit_b);
                pend <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
        if (model_en && unit_start != '0) begin
            pend     <= 1'b1;
            pend_cnt <= model_lat;
            for (int i = 0; i < N_UNITS; i++) begin
                if (unit_start[i]) pend_op <= i;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and returns once rsp_valid is seen (rsp_ready held
    // low). lat counts clock edges from the accept edge through the edge at
    // which rsp_valid rises. spur>0 pulses unit_done[2] in that lat cycle.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int spur, output int lat, output int starts, output int busy_drop);
        int n;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        starts = 0;
        busy_drop = 0;
        while (!rsp_valid && lat < 100) begin
            starts += $countones(unit_start);
            if (!busy) busy_drop++;
            tick();
            lat++;
            extra_done = (lat == spur) ? 8'h04 : 8'h00;
        end
        extra_done = '0;
        $display("[TB] op=%0d a=%02h b=%02h -> res=%04h err=%0d rsp_op=%0d lat=%0d starts=%0d",
                 op, a, b, rsp_res, rsp_err, rsp_op, lat, starts);
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq(tag, {30'd0, rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        int lat, starts, bdrop, bad, n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;
        extra_done = '0;
        model_en   = 1'b1;
        model_lat  = 1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_eq("rst_ctrl", {req_ready, rsp_valid, busy, rsp_err}, 32'b1000);
        check_eq("rst_data", {rsp_res, unit_a, unit_b}, 32'd0);
        check_eq("rst_start_op", {unit_start, 5'd0, rsp_op}, 32'd0);

        // AND F0 & 3C with done two edges after start
        run_op(3'd0, 8'hF0, 8'h3C, 0, lat, starts, bdrop);
        check_eq("and_res", 32'(rsp_res), 32'h0030);
        check_eq("and_err", 32'(rsp_err), 32'd0);
        check_eq("and_lat", 32'(lat), 32'd4);
        check_eq("and_starts", 32'(starts), 32'd1);
        check_eq("and_rsp_op", 32'(rsp_op), 32'd0);

        // Backpressure with a second request waiting
        req_op    = 3'd1;
        req_a     = 8'h0F;
        req_b     = 8'hF0;
        req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rsp_valid || rsp_res !== 16'h0030 || req_ready || unit_start != '0) bad++;
        end
        check_eq("bp_hold", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("bp_release", {30'd0, req_ready, busy}, 32'b10);
        tick();
        req_valid = 1'b0;
        check_eq("bp_accept_start", 32'(unit_start), 32'h02);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check_eq("bp_or_res", {rsp_err, 15'd0, rsp_res}, 32'h0000_00FF);
        $display("[TB] op=1 a=0f b=f0 (queued) -> res=%04h err=%0d", rsp_res, rsp_err);
        finish_rsp("bp_done");

        // Illegal opcode: slot 7 not populated
        run_op(3'd7, 8'h12, 8'h34, 0, lat, starts, bdrop);
        check_eq("ill_err_res", {rsp_err, 15'd0, rsp_res}, 32'h8000_0000);
        check_eq("ill_lat", 32'(lat), 32'd1);
        check_eq("ill_starts", 32'(starts), 32'd0);
        check_eq("ill_rsp_op", 32'(rsp_op), 32'd7);
        finish_rsp("ill_done");

        // Timeout: unit never answers, 8 WAIT cycles
        model_en = 1'b0;
        run_op(3'd0, 8'hAA, 8'h55, 0, lat, starts, bdrop);
        check_eq("to_err_res", {rsp_err, 15'd0, rsp_res}, 32'h8000_0000);
        check_eq("to_lat", 32'(lat), 32'd10);
        check_eq("to_busy", 32'(bdrop), 32'd0);
        check_eq("to_starts", 32'(starts), 32'd1);
        finish_rsp("to_done");
        model_en = 1'b1;

        // Spurious done[2] in the first WAIT cycle while unit 0 takes longer
        model_lat = 3;
        run_op(3'd0, 8'hFF, 8'h55, 2, lat, starts, bdrop);
        check_eq("spur_res", {rsp_err, 15'd0, rsp_res}, 32'h0000_0055);
        check_eq("spur_lat", 32'(lat), 32'd6);
        finish_rsp("spur_done");

        // Done on the final watchdog cycle wins over timeout
        model_lat = 7;
        run_op(3'd1, 8'h81, 8'h18, 0, lat, starts, bdrop);
        check_eq("last_res", {rsp_err, 15'd0, rsp_res}, 32'h0000_0099);
        check_eq("last_lat", 32'(lat), 32'd10);
        finish_rsp("last_done");

        // Done one cycle too late is a timeout
        model_lat = 8;
        run_op(3'd0, 8'h0F, 8'h0F, 0, lat, starts, bdrop);
        check_eq("late_err_res", {rsp_err, 15'd0, rsp_res}, 32'h8000_0000);
        finish_rsp("late_done");
        tick();
        tick();

        // Reset in the middle of WAIT
        model_lat = 5;
        req_op    = 3'd0;
        req_a     = 8'h3C;
        req_b     = 8'hC3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check_eq("mid_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_ctrl", {req_ready, rsp_valid, busy, rsp_err}, 32'b1000);
        check_eq("mid_rst_data", {rsp_res, unit_a, unit_b}, 32'd0);
        check_eq("mid_rst_start_op", {unit_start, 5'd0, rsp_op}, 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid || busy) bad++;
        end
        check_eq("mid_stale_done", 32'(bad), 32'd0);
        $display("[TB] reset mid-WAIT, stale done ignored (bad cycles=%0d)", bad);
        model_lat = 1;
        run_op(3'd1, 8'h0F, 8'hF0, 0, lat, starts, bdrop);
        check_eq("post_rst_res", {rsp_err, 15'd0, rsp_res}, 32'h0000_00FF);
        check_eq("post_rst_lat", 32'(lat), 32'd4);
        finish_rsp("post_rst_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
